// File: rtl/function04_pkg.sv
// rtl/function04_pkg.sv - shared constants and reference evaluator for function04
package function04_pkg;

    // Bit i holds f for input index i = {a,b,c}.
    localparam logic [7:0] F04_TT = 8'b1110_0010;

    // Default width of the f-high cycle counter.
    localparam int F04_CNT_W = 8;

    // Table lookup form of the function.
    function automatic logic f04_eval(input logic a, input logic b, input logic c);
        logic [2:0] idx;
        idx = {a, b, c};
        return F04_TT[idx];
    endfunction

endpackage

// File: rtl/function04_core.sv
// rtl/function04_core.sv - combinational core f = a&b | ~b&c
module function04_core (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic f
);

    // Sum-of-products form; b selects between a (b=1) and c (b=0).
    assign f = (a & b) | (~b & c);

endmodule

// File: rtl/function04.sv
// rtl/function04.sv - 3-input function with registered copy, edge pulses and saturating high counter
module function04
    import function04_pkg::*;
#(
    parameter int CNT_W = F04_CNT_W
) (
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             f,
    input  logic             clk,
    input  logic             reset_n,
    output logic             f_q,
    output logic             f_rise,
    output logic             f_fall,
    output logic [CNT_W-1:0] hi_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The combinational result is independent of clk and reset_n.
    function04_core u_core (
        .a (a),
        .b (b),
        .c (c),
        .f (f)
    );

    // Observation stage: edge pulses use the pre-edge f_q, counter holds at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q    <= 1'b0;
            f_rise <= 1'b0;
            f_fall <= 1'b0;
            hi_cnt <= '0;
        end else begin
            f_q    <= f;
            f_rise <= f & ~f_q;
            f_fall <= ~f & f_q;
            if (f && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_function04.sv
// tb/tb_function04.sv - self-checking bench for function04
module tb_function04;

    logic       a, b, c;
    logic       f;
    logic       clk;
    logic       reset_n;
    logic       f_q, f_rise, f_fall;
    logic [7:0] hi_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] ref_tt = 8'b1110_0010;
    int         m_fq, m_rise, m_fall, m_cnt;

    typedef struct {
        logic [2:0] abc;
        logic       exp_f;
    } vec_t;
    vec_t tbl[8];

    function04 #(.CNT_W(8)) dut (
        .a       (a),
        .b       (b),
        .c       (c),
        .f       (f),
        .clk     (clk),
        .reset_n (reset_n),
        .f_q     (f_q),
        .f_rise  (f_rise),
        .f_fall  (f_fall),
        .hi_cnt  (hi_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int ref_f(input logic [2:0] abc);
        logic [7:0] tt;
        tt = ref_tt;
        return int'(tt[abc]);
    endfunction

    task automatic model_reset();
        m_fq = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".f_q"},    int'(f_q),    m_fq);
        chk({tag, ".f_rise"}, int'(f_rise), m_rise);
        chk({tag, ".f_fall"}, int'(f_fall), m_fall);
        chk({tag, ".hi_cnt"}, int'(hi_cnt), m_cnt);
    endtask

    // Called just after a negedge: drive inputs, take one rising edge, compare at the next negedge.
    task automatic cycle(input logic [2:0] abc, input string tag, input bit full);
        int mf;
        {a, b, c} = abc;
        #1;
        mf = ref_f(abc);
        if (full) chk({tag, ".f"}, int'(f), mf);
        @(posedge clk);
        m_rise = mf & (1 - m_fq);
        m_fall = (1 - mf) & m_fq;
        m_fq   = mf;
        if (mf == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
        @(negedge clk);
        if (full) check_regs(tag);
    endtask

    initial begin
        tbl[0] = '{3'b000, 1'b0};
        tbl[1] = '{3'b001, 1'b1};
        tbl[2] = '{3'b010, 1'b0};
        tbl[3] = '{3'b011, 1'b0};
        tbl[4] = '{3'b100, 1'b0};
        tbl[5] = '{3'b101, 1'b1};
        tbl[6] = '{3'b110, 1'b1};
        tbl[7] = '{3'b111, 1'b1};

        reset_n = 1'b0;
        {a, b, c} = 3'b000;
        model_reset();
        #3;
        check_regs("reset");

        // Exhaustive combinational sweep with the observation stage held in reset
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = tbl[i].abc;
            #20;
            chk($sformatf("sweep%0d.f", i), int'(f), int'(tbl[i].exp_f));
        end

        // Edge sequence 000 -> 001 -> 011
        @(negedge clk);
        reset_n = 1'b1;
        cycle(3'b000, "edge0", 1'b1);
        chk("edge0.fq_const", int'(f_q), 0);
        cycle(3'b001, "edge1", 1'b1);
        chk("edge1.rise_const", int'(f_rise), 1);
        chk("edge1.fq_const", int'(f_q), 1);
        cycle(3'b011, "edge2", 1'b1);
        chk("edge2.fall_const", int'(f_fall), 1);
        chk("edge2.fq_const", int'(f_q), 0);
        chk("edge2.rise_const", int'(f_rise), 0);

        // Async reset mid-cycle with hi_cnt=5 and f_q=1
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) cycle(3'b111, "pre_rst", 1'b0);
        chk("pre_rst.hi_cnt", int'(hi_cnt), 5);
        chk("pre_rst.f_q", int'(f_q), 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        chk("async_rst.f111", int'(f), 1);
        {a, b, c} = 3'b010;
        #1;
        chk("async_rst.f010", int'(f), 0);
        {a, b, c} = 3'b001;
        #1;
        chk("async_rst.f001", int'(f), 1);
        @(posedge clk);
        #1;
        check_regs("rst_held");

        // Post-reset: release with abc=101, first edge samples normally
        @(negedge clk);
        {a, b, c} = 3'b101;
        reset_n = 1'b1;
        cycle(3'b101, "post_rst", 1'b1);
        chk("post_rst.fq_const", int'(f_q), 1);
        chk("post_rst.rise_const", int'(f_rise), 1);
        chk("post_rst.cnt_const", int'(hi_cnt), 1);

        // Saturation: 111 held 300 cycles
        for (int i = 0; i < 300; i++) cycle(3'b111, "sat", 1'b0);
        chk("sat.hi_cnt", int'(hi_cnt), 255);
        check_regs("sat");
        cycle(3'b111, "sat_hold", 1'b1);
        chk("sat_hold.hi_cnt", int'(hi_cnt), 255);

        // Randomized stimulus against the model
        reset_n = 1'b0;
        #1;
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [2:0] r;
            r = 3'($urandom_range(0, 7));
            cycle(r, "rand", 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
